// File: rtl/shift_pattern_checker_if.sv
// Bundle carrying the observed shift-counter pattern into the checker and its
// decoded status back out to whoever drives or observes the pattern.
interface shift_pattern_checker_if #(
    parameter int WIDTH = 8
);
    localparam int POS_W = $clog2(WIDTH);

    logic [WIDTH-1:0] pattern;
    logic [POS_W-1:0] pos;
    logic             dir;
    logic             locked;
    logic             err;
    logic [7:0]       err_count;
    logic [7:0]       sweeps;

    modport master (
        output pattern,
        input  pos, dir, locked, err, err_count, sweeps
    );

    modport slave (
        input  pattern,
        output pos, dir, locked, err, err_count, sweeps
    );
endinterface

// File: rtl/shift_pattern_checker.sv
// Receive-side monitor for the bouncing one-hot shift pattern: locks onto the
// sequence, decodes position/direction, counts round trips and flags deviations.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_HUNT   | not tracking, waiting for the LSB value to start
// S_BOTTOM | LSB value seen, counting its dwell
// S_UP     | one-hot bit marching towards the MSB
// S_TOP    | MSB just reached, next sample must repeat it
// S_DOWN   | MSB hold seen, bit marching back towards the LSB
module shift_pattern_checker #(
    parameter int WIDTH = 8,
    parameter int DWELL = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    shift_pattern_checker_if.slave bus
);
    localparam int POS_W = $clog2(WIDTH);
    localparam int DW_W  = $clog2(DWELL + 1);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_HUNT,
        S_BOTTOM,
        S_UP,
        S_TOP,
        S_DOWN
    } state_t;

    state_t            state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              dir_q, dir_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [7:0]        err_count_q, err_count_d;
    logic [7:0]        sweeps_q, sweeps_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic              first_q, first_d;

    logic [WIDTH-1:0]  sample;
    logic [WIDTH-1:0]  prev;
    logic              bad;

    assign sample = bus.pattern;

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        locked_d    = locked_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        sweeps_d    = sweeps_q;
        dwell_d     = dwell_q;
        first_d     = first_q;
        bad         = 1'b0;

        // Outside the bottom dwell the last accepted sample is implied by pos.
        prev        = '0;
        prev[pos_q] = 1'b1;

        case (state_q)
            S_HUNT: begin
                if (sample == ONE) begin
                    state_d = S_BOTTOM;
                    dwell_d = DW_W'(1);
                    first_d = 1'b1;
                    pos_d   = '0;
                    dir_d   = 1'b1;
                end
            end
            S_BOTTOM: begin
                if (sample == ONE) begin
                    if (dwell_q >= DW_W'(DWELL)) bad = 1'b1;
                    else dwell_d = dwell_q + 1'b1;
                end else if (sample == TWO &&
                             (first_q || dwell_q >= DW_W'(DWELL - 1))) begin
                    state_d  = S_UP;
                    pos_d    = POS_W'(1);
                    dir_d    = 1'b1;
                    locked_d = 1'b1;
                    first_d  = 1'b0;
                end else begin
                    bad = 1'b1;
                end
            end
            S_UP: begin
                if (sample == (prev << 1)) begin
                    pos_d = pos_q + 1'b1;
                    if (sample == MSB) state_d = S_TOP;
                end else begin
                    bad = 1'b1;
                end
            end
            S_TOP: begin
                if (sample == MSB) begin
                    state_d = S_DOWN;
                    dir_d   = 1'b0;
                end else begin
                    bad = 1'b1;
                end
            end
            S_DOWN: begin
                if (sample == (prev >> 1)) begin
                    pos_d = pos_q - 1'b1;
                    if (sample == ONE) begin
                        state_d  = S_BOTTOM;
                        dwell_d  = DW_W'(1);
                        first_d  = 1'b0;
                        dir_d    = 1'b1;
                        sweeps_d = sweeps_q + 8'd1;
                    end
                end else begin
                    bad = 1'b1;
                end
            end
            default: state_d = S_HUNT;
        endcase

        // An offending LSB sample restarts a dwell so relock needs no extra cycle.
        if (bad) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            pos_d    = pos_q;
            dir_d    = dir_q;
            sweeps_d = sweeps_q;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            if (sample == ONE) begin
                state_d = S_BOTTOM;
                dwell_d = DW_W'(1);
                first_d = 1'b1;
            end else begin
                state_d = S_HUNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_HUNT;
            pos_q       <= '0;
            dir_q       <= 1'b1;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
            sweeps_q    <= 8'd0;
            dwell_q     <= '0;
            first_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            sweeps_q    <= sweeps_d;
            dwell_q     <= dwell_d;
            first_q     <= first_d;
        end
    end

    assign bus.pos       = pos_q;
    assign bus.dir       = dir_q;
    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;
    assign bus.sweeps    = sweeps_q;
endmodule
